// File: rtl/id_stage_pipe_if.sv
// Fetch-to-decode and decode-to-execute handshake/payload bundle for id_stage_pipe.
// The master modport is the fetch/execute environment; the slave modport is the stage.
interface id_stage_pipe_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc2;
    logic [1:0]        rd_sel;
    logic              reg_write;
    logic              imm_sign;
    logic              imm_len;
    logic              uses_rs;
    logic              uses_rt;
    logic              ex_load;
    logic [2:0]        ex_wr_sel;
    logic              wb_en;
    logic [2:0]        wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_jaddr;
    logic [4:0]        out_opcode;
    logic [1:0]        out_func;
    logic [2:0]        out_wr_sel;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_pc2;

    modport master (
        output in_valid, instr, pc2, rd_sel, reg_write, imm_sign, imm_len,
               uses_rs, uses_rt, ex_load, ex_wr_sel, wb_en, wb_sel, wb_data,
               flush, out_ready,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
               out_jaddr, out_opcode, out_func, out_wr_sel, out_wr_en, out_pc2
    );

    modport slave (
        input  in_valid, instr, pc2, rd_sel, reg_write, imm_sign, imm_len,
               uses_rs, uses_rt, ex_load, ex_wr_sel, wb_en, wb_sel, wb_data,
               flush, out_ready,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm,
               out_jaddr, out_opcode, out_func, out_wr_sel, out_wr_en, out_pc2
    );
endinterface

// File: rtl/id_stage_pipe.sv
// WiscSP13 decode stage: register file with optional writeback bypass, immediate and
// jump-target generation, load-use stall detection and a registered decode/execute slot.
module id_stage_pipe #(
    parameter int DATA_W    = 16,
    parameter int BYPASS    = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    localparam logic BYPASS_ON = (BYPASS != 32'sd0);
    localparam logic HAZARD_ON = (HAZARD_EN != 32'sd0);

    logic [DATA_W-1:0] regs_r [8];

    logic [2:0]        rs_sel_s;
    logic [2:0]        rt_sel_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] jaddr_s;
    logic [2:0]        wr_sel_s;
    logic              hazard_s;
    logic              slot_free_s;
    logic              in_ready_s;
    logic              load_s;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_rs_data_r;
    logic [DATA_W-1:0] out_rt_data_r;
    logic [DATA_W-1:0] out_imm_r;
    logic [DATA_W-1:0] out_jaddr_r;
    logic [4:0]        out_opcode_r;
    logic [1:0]        out_func_r;
    logic [2:0]        out_wr_sel_r;
    logic              out_wr_en_r;
    logic [DATA_W-1:0] out_pc2_r;

    assign rs_sel_s = bus.instr[10:8];
    assign rt_sel_s = bus.instr[7:5];

    // Register file read ports; a same-cycle writeback wins when bypass is built in.
    always_comb begin
        rs_data_s = regs_r[rs_sel_s];
        rt_data_s = regs_r[rt_sel_s];
        if (BYPASS_ON && bus.wb_en && (bus.wb_sel == rs_sel_s)) begin
            rs_data_s = bus.wb_data;
        end else begin
            rs_data_s = regs_r[rs_sel_s];
        end
        if (BYPASS_ON && bus.wb_en && (bus.wb_sel == rt_sel_s)) begin
            rt_data_s = bus.wb_data;
        end else begin
            rt_data_s = regs_r[rt_sel_s];
        end
    end

    // Immediate extension from either the 8-bit or the 5-bit field.
    always_comb begin
        imm_s = {DATA_W{1'b0}};
        if (bus.imm_len) begin
            imm_s = {{(DATA_W-8){bus.imm_sign & bus.instr[7]}}, bus.instr[7:0]};
        end else begin
            imm_s = {{(DATA_W-5){bus.imm_sign & bus.instr[4]}}, bus.instr[4:0]};
        end
    end

    // PC-relative target; carry-out is intentionally dropped so the address wraps.
    assign jaddr_s = {{(DATA_W-11){bus.instr[10]}}, bus.instr[10:0]} + bus.pc2;

    // Destination register selection.
    always_comb begin
        wr_sel_s = 3'd0;
        case (bus.rd_sel)
            2'd0:    wr_sel_s = bus.instr[7:5];
            2'd1:    wr_sel_s = bus.instr[4:2];
            2'd2:    wr_sel_s = bus.instr[10:8];
            2'd3:    wr_sel_s = 3'b111;
            default: wr_sel_s = 3'd0;
        endcase
    end

    assign hazard_s = HAZARD_ON & bus.in_valid & bus.ex_load &
                      ((bus.uses_rs & (bus.ex_wr_sel == rs_sel_s)) |
                       (bus.uses_rt & (bus.ex_wr_sel == rt_sel_s)));

    assign slot_free_s = ~out_valid_r | bus.out_ready;
    assign in_ready_s  = slot_free_s & ~hazard_s & ~bus.flush;
    assign load_s      = slot_free_s & bus.in_valid & ~hazard_s;

    // Register file write port; flush does not suppress writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (bus.wb_en) begin
            regs_r[bus.wb_sel] <= bus.wb_data;
        end else begin
            regs_r[bus.wb_sel] <= regs_r[bus.wb_sel];
        end
    end

    // Decode/execute slot: reset, flush, load, bubble, then hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_rs_data_r <= {DATA_W{1'b0}};
            out_rt_data_r <= {DATA_W{1'b0}};
            out_imm_r     <= {DATA_W{1'b0}};
            out_jaddr_r   <= {DATA_W{1'b0}};
            out_opcode_r  <= 5'd0;
            out_func_r    <= 2'd0;
            out_wr_sel_r  <= 3'd0;
            out_wr_en_r   <= 1'b0;
            out_pc2_r     <= {DATA_W{1'b0}};
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r   <= 1'b1;
            out_rs_data_r <= rs_data_s;
            out_rt_data_r <= rt_data_s;
            out_imm_r     <= imm_s;
            out_jaddr_r   <= jaddr_s;
            out_opcode_r  <= bus.instr[15:11];
            out_func_r    <= bus.instr[1:0];
            out_wr_sel_r  <= wr_sel_s;
            out_wr_en_r   <= bus.reg_write;
            out_pc2_r     <= bus.pc2;
        end else if (slot_free_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_rs_data = out_rs_data_r;
    assign bus.out_rt_data = out_rt_data_r;
    assign bus.out_imm     = out_imm_r;
    assign bus.out_jaddr   = out_jaddr_r;
    assign bus.out_opcode  = out_opcode_r;
    assign bus.out_func    = out_func_r;
    assign bus.out_wr_sel  = out_wr_sel_r;
    assign bus.out_wr_en   = out_wr_en_r;
    assign bus.out_pc2     = out_pc2_r;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a reference model pushes expected slot contents at
// acceptance and they are compared while the slot is valid. A BYPASS=0 twin shares the inputs.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(16)) b0 ();
    id_stage_pipe_if #(.DATA_W(16)) b1 ();

    id_stage_pipe #(.DATA_W(16), .BYPASS(1), .HAZARD_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    id_stage_pipe #(.DATA_W(16), .BYPASS(0), .HAZARD_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    assign b1.in_valid  = b0.in_valid;
    assign b1.instr     = b0.instr;
    assign b1.pc2       = b0.pc2;
    assign b1.rd_sel    = b0.rd_sel;
    assign b1.reg_write = b0.reg_write;
    assign b1.imm_sign  = b0.imm_sign;
    assign b1.imm_len   = b0.imm_len;
    assign b1.uses_rs   = b0.uses_rs;
    assign b1.uses_rt   = b0.uses_rt;
    assign b1.ex_load   = b0.ex_load;
    assign b1.ex_wr_sel = b0.ex_wr_sel;
    assign b1.wb_en     = b0.wb_en;
    assign b1.wb_sel    = b0.wb_sel;
    assign b1.wb_data   = b0.wb_data;
    assign b1.flush     = b0.flush;
    assign b1.out_ready = b0.out_ready;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] imm;
        logic [15:0] jaddr;
        logic [4:0]  op;
        logic [1:0]  fn;
        logic [2:0]  wsel;
        logic        we;
        logic [15:0] pc2;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mreg [8];
    logic        mvalid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_decode();
        exp_t        e;
        logic [15:0] ins;
        ins    = b0.instr;
        e.rs   = (b0.wb_en && b0.wb_sel == ins[10:8]) ? b0.wb_data : mreg[ins[10:8]];
        e.rt   = (b0.wb_en && b0.wb_sel == ins[7:5])  ? b0.wb_data : mreg[ins[7:5]];
        if (b0.imm_len) begin
            e.imm = b0.imm_sign ? {{8{ins[7]}}, ins[7:0]} : {8'h00, ins[7:0]};
        end else begin
            e.imm = b0.imm_sign ? {{11{ins[4]}}, ins[4:0]} : {11'h000, ins[4:0]};
        end
        e.jaddr = {{5{ins[10]}}, ins[10:0]} + b0.pc2;
        e.op    = ins[15:11];
        e.fn    = ins[1:0];
        case (b0.rd_sel)
            2'd0:    e.wsel = ins[7:5];
            2'd1:    e.wsel = ins[4:2];
            2'd2:    e.wsel = ins[10:8];
            default: e.wsel = 3'b111;
        endcase
        e.we  = b0.reg_write;
        e.pc2 = b0.pc2;
        return e;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check the slot after it.
    task automatic step(input bit chk_rdy);
        logic haz, sfree;
        @(negedge clk);
        haz   = b0.in_valid & b0.ex_load &
                ((b0.uses_rs & (b0.ex_wr_sel == b0.instr[10:8])) |
                 (b0.uses_rt & (b0.ex_wr_sel == b0.instr[7:5])));
        sfree = !mvalid || b0.out_ready;
        if (chk_rdy) chk("in_ready", b0.in_ready, sfree & !haz & !b0.flush);
        if (rst) begin
            sb.delete();
            mvalid = 1'b0;
            for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
        end else begin
            if (mvalid && (b0.flush || b0.out_ready) && sb.size() > 0) void'(sb.pop_front());
            if (b0.flush) begin
                mvalid = 1'b0;
            end else if (sfree && b0.in_valid && !haz) begin
                sb.push_back(model_decode());
                mvalid = 1'b1;
            end else if (sfree) begin
                mvalid = 1'b0;
            end
            if (b0.wb_en) mreg[b0.wb_sel] = b0.wb_data;
        end
        @(posedge clk);
        #1;
        chk("out_valid", b0.out_valid, mvalid);
        if (mvalid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'd0, 64'd1);
            end else begin
                chk("rs_data", b0.out_rs_data, sb[0].rs);
                chk("rt_data", b0.out_rt_data, sb[0].rt);
                chk("imm",     b0.out_imm,     sb[0].imm);
                chk("jaddr",   b0.out_jaddr,   sb[0].jaddr);
                chk("opcode",  b0.out_opcode,  sb[0].op);
                chk("func",    b0.out_func,    sb[0].fn);
                chk("wr_sel",  b0.out_wr_sel,  sb[0].wsel);
                chk("wr_en",   b0.out_wr_en,   sb[0].we);
                chk("pc2",     b0.out_pc2,     sb[0].pc2);
            end
        end
    endtask

    task automatic chk_zero_payload();
        chk("z_rs",    b0.out_rs_data, 16'h0000);
        chk("z_rt",    b0.out_rt_data, 16'h0000);
        chk("z_imm",   b0.out_imm,     16'h0000);
        chk("z_jaddr", b0.out_jaddr,   16'h0000);
        chk("z_op",    b0.out_opcode,  5'd0);
        chk("z_wsel",  b0.out_wr_sel,  3'd0);
        chk("z_we",    b0.out_wr_en,   1'b0);
        chk("z_pc2",   b0.out_pc2,     16'h0000);
    endtask

    initial begin
        mvalid       = 1'b0;
        rst          = 1'b1;
        b0.in_valid  = 1'b0; b0.instr   = 16'h0000; b0.pc2      = 16'h0000;
        b0.rd_sel    = 2'd0; b0.reg_write = 1'b0;   b0.imm_sign = 1'b0;
        b0.imm_len   = 1'b0; b0.uses_rs = 1'b0;     b0.uses_rt  = 1'b0;
        b0.ex_load   = 1'b0; b0.ex_wr_sel = 3'd0;   b0.wb_en    = 1'b0;
        b0.wb_sel    = 3'd0; b0.wb_data = 16'h0000; b0.flush    = 1'b0;
        b0.out_ready = 1'b1;
        step(1'b0);
        step(1'b1);
        chk_zero_payload();
        rst = 1'b0;

        // Writeback bypass on r3 in the acceptance cycle.
        b0.in_valid = 1'b1; b0.instr = 16'h0300; b0.uses_rs = 1'b1; b0.pc2 = 16'h0100;
        b0.wb_en = 1'b1; b0.wb_sel = 3'd3; b0.wb_data = 16'h1234; b0.reg_write = 1'b1;
        step(1'b1);
        chk("bypass1_rs", b0.out_rs_data, 16'h1234);
        chk("bypass0_valid", b1.out_valid, 1'b1);
        chk("bypass0_rs", b1.out_rs_data, 16'h0000);
        b0.wb_en = 1'b0;

        // Immediate forms.
        b0.instr = 16'h00F0; b0.imm_len = 1'b1; b0.imm_sign = 1'b1; b0.rd_sel = 2'd1;
        step(1'b1);
        chk("imm8_sx", b0.out_imm, 16'hFFF0);
        b0.imm_sign = 1'b0; b0.rd_sel = 2'd2;
        step(1'b1);
        chk("imm8_zx", b0.out_imm, 16'h00F0);
        b0.imm_len = 1'b0; b0.imm_sign = 1'b1; b0.rd_sel = 2'd3;
        step(1'b1);
        chk("imm5_sx", b0.out_imm, 16'hFFF0);

        // Jump target wrap-around in both directions.
        b0.pc2 = 16'hFFFE; b0.instr = 16'hA004; b0.rd_sel = 2'd0;
        step(1'b1);
        chk("jaddr_wrap", b0.out_jaddr, 16'h0002);
        b0.pc2 = 16'h0010; b0.instr = 16'h27FE;
        step(1'b1);
        chk("jaddr_neg", b0.out_jaddr, 16'h000E);

        // Load-use stall then release.
        b0.instr = 16'h4043; b0.uses_rs = 1'b0; b0.uses_rt = 1'b1;
        b0.ex_load = 1'b1; b0.ex_wr_sel = 3'd2;
        step(1'b1);
        chk("hazard_bubble", b0.out_valid, 1'b0);
        b0.ex_load = 1'b0;
        step(1'b1);
        chk("hazard_release", b0.out_valid, 1'b1);

        // Backpressure: slot holds for three cycles, then the waiting instruction enters.
        b0.instr = 16'h5555; b0.pc2 = 16'h0200;
        step(1'b1);
        b0.out_ready = 1'b0; b0.instr = 16'h6AA9; b0.pc2 = 16'h0202;
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk("bp_hold_pc2", b0.out_pc2, 16'h0200);
        end
        b0.out_ready = 1'b1;
        step(1'b1);
        chk("bp_next_pc2", b0.out_pc2, 16'h0202);

        // Flush with concurrent writeback of r5, then read r5 back.
        b0.flush = 1'b1; b0.wb_en = 1'b1; b0.wb_sel = 3'd5; b0.wb_data = 16'hBEEF;
        step(1'b1);
        chk("flush_valid", b0.out_valid, 1'b0);
        b0.flush = 1'b0; b0.wb_en = 1'b0; b0.instr = 16'h0500; b0.uses_rs = 1'b1;
        b0.uses_rt = 1'b0;
        step(1'b1);
        chk("r5_after_flush", b0.out_rs_data, 16'hBEEF);

        // Reset in the middle of a backpressure stall.
        b0.out_ready = 1'b0; b0.instr = 16'h0360;
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        chk("rst_stall_valid", b0.out_valid, 1'b0);
        chk_zero_payload();
        rst = 1'b0; b0.out_ready = 1'b1; b0.instr = 16'h0560; b0.uses_rt = 1'b1;
        step(1'b1);
        chk("rst_r5", b0.out_rs_data, 16'h0000);
        chk("rst_r3", b0.out_rt_data, 16'h0000);
        b0.in_valid = 1'b0;
        step(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
